pc_fetch_stage: RTL and testbench

Instruction-fetch front end of the RV32I core. It holds the architectural program counter, drives it to the PCPlus4 adder and to instruction memory, and selects the next PC from the adder result or a redirect from execute. It also registers each fetched instruction with its PC into the IF/ID output slot consumed by decode, honouring stall and flush.

---
 rtl/pc_fetch_stage.sv | 124 ++++++++++++
 tb/tb_pc_fetch_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch front end: owns the architectural PC, issues one request at a
// time to instruction memory, and fills the IF/ID slot while honouring stall and redirect.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] pcplus4,
  output logic [31:0] pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t      state_r;
  logic        kill_r;
  logic [31:0] hold_r;

  logic        slot_free_s;
  logic        consume_s;
  logic [31:0] redirect_target_s;

  assign slot_free_s       = !if_valid || !stall;
  assign consume_s         = if_valid && !stall;
  assign redirect_target_s = {redirect_pc[31:2], 2'b00};

  assign imem_req_valid = (state_r == ST_REQ);
  assign imem_addr      = pc;

  // Fetch FSM, PC register, hold buffer and IF/ID slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_REQ;
      kill_r   <= 1'b0;
      hold_r   <= 32'h0000_0000;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= 32'h0000_0000;
      if_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      // A request already in flight must have its response swallowed by kill.
      pc       <= redirect_target_s;
      if_valid <= 1'b0;
      kill_r   <= 1'b0;
      state_r  <= ST_REQ;
      case (state_r)
        ST_REQ: begin
          if (imem_req_ready) begin
            state_r <= ST_WAIT;
            kill_r  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (!imem_resp_valid) begin
            state_r <= ST_WAIT;
            kill_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_REQ;
        end
      endcase
    end else begin
      if (consume_s) begin
        if_valid <= 1'b0;
      end
      case (state_r)
        ST_REQ: begin
          if (imem_req_ready) begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            if (kill_r) begin
              kill_r  <= 1'b0;
              state_r <= ST_REQ;
            end else if (slot_free_s) begin
              if_valid <= 1'b1;
              if_pc    <= pc;
              if_instr <= imem_resp_data;
              pc       <= pcplus4;
              state_r  <= ST_REQ;
            end else begin
              hold_r  <= imem_resp_data;
              state_r <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // pc is frozen while holding, so it still names the buffered word.
          if (slot_free_s) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
            if_instr <= hold_r;
            pc       <= pcplus4;
            state_r  <= ST_REQ;
          end
        end
        default: begin
          state_r <= ST_REQ;
          kill_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed test-plan steps followed by random traffic,
// checked against an in-order instruction-stream scoreboard and a memory model.
module tb_pc_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pcplus4;
  logic [31:0] pc;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int errors = 0;
  int checks = 0;

  // Scoreboard: the PC the next instruction delivered to decode must carry.
  logic [31:0] exp_pc;
  int          n_consumed = 0;

  // Memory model state.
  bit          outstanding;
  logic [31:0] mem_addr;
  int          cnt;
  int          lat_min;
  int          lat_max;
  bit          stale;

  pc_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pcplus4        (pcplus4),
    .pc             (pc),
    .imem_req_valid (imem_req_valid),
    .imem_addr      (imem_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pcplus4 = pc + 32'd4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"}, pc, RESET_PC);
    chk({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_if_pc"}, if_pc, 32'd0);
    chk({tag, "_if_instr"}, if_instr, NOP);
    chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd1);
    chk({tag, "_addr"}, imem_addr, RESET_PC);
  endtask

  // One clock cycle: sample before the edge, update models, check after the edge.
  task automatic step();
    bit          acc;
    bit          fire;
    bit          cons;
    bit          redir;
    bit          pending;
    logic [31:0] target;
    logic [31:0] addr_b;
    acc     = imem_req_valid && imem_req_ready;
    fire    = imem_resp_valid;
    cons    = if_valid && !stall;
    redir   = redirect_valid;
    target  = redirect_pc & 32'hFFFF_FFFC;
    addr_b  = imem_addr;
    pending = imem_req_valid && !imem_req_ready && !redir;
    if (imem_req_valid) chk("one_outstanding", {31'd0, outstanding}, 32'd0);
    if (redir) begin
      exp_pc = target;
    end else if (cons) begin
      chk("stream_pc", if_pc, exp_pc);
      chk("stream_data", if_instr, exp_pc ^ KEY);
      exp_pc = exp_pc + 32'd4;
      n_consumed++;
    end
    @(posedge clk);
    #1;
    if (redir) begin
      chk("redirect_flush", {31'd0, if_valid}, 32'd0);
      chk("redirect_pc", pc, target);
    end
    if (pending) begin
      chk("req_held", {31'd0, imem_req_valid}, 32'd1);
      chk("addr_stable", imem_addr, addr_b);
    end
    if (fire) outstanding = 1'b0;
    if (acc) begin
      outstanding = 1'b1;
      mem_addr    = addr_b;
      cnt         = $urandom_range(lat_max, lat_min);
    end
    if (stale) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hDEAD_BEEF;
    end else if (outstanding && cnt <= 1) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_addr ^ KEY;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (outstanding) cnt--;
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'd0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    exp_pc          = RESET_PC;
    outstanding     = 1'b0;
    mem_addr        = 32'd0;
    cnt             = 0;
    lat_min         = 1;
    lat_max         = 1;
    stale           = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Sequential fetch: one instruction every 2 cycles at 0,4,8,C.
    chk("first_req", {31'd0, imem_req_valid}, 32'd1);
    chk("first_addr", imem_addr, RESET_PC);
    step();
    chk("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("seq_valid", {31'd0, if_valid}, 32'd1);
      chk("seq_pc", if_pc, 32'(4 * k));
      chk("seq_instr", if_instr, 32'(4 * k) ^ KEY);
      if (k < 3) begin
        step();
        chk("seq_gap", {31'd0, if_valid}, 32'd0);
      end
    end

    // Stall for 6 cycles while the next response arrives.
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("stall_pc_frozen", pc, 32'h0000_0010);
      chk("stall_slot_pc", if_pc, 32'h0000_000C);
      chk("stall_slot_valid", {31'd0, if_valid}, 32'd1);
    end
    stall = 1'b0;
    step();
    chk("release_valid", {31'd0, if_valid}, 32'd1);
    chk("release_pc", if_pc, 32'h0000_0010);
    chk("release_instr", if_instr, 32'h0000_0010 ^ KEY);

    // Redirect while waiting for a slow response.
    lat_min = 3;
    lat_max = 3;
    step();
    chk("in_wait", {31'd0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    chk("kill_wait", {31'd0, imem_req_valid}, 32'd0);
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 10 && !imem_req_valid; i++) step();
    chk("redir_req", {31'd0, imem_req_valid}, 32'd1);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    for (int i = 0; i < 10 && !if_valid; i++) step();
    chk("redir_slot_pc", if_pc, 32'h0000_0100);

    // Redirect while stalled with a word in the hold buffer.
    stall = 1'b1;
    step();
    step();
    step();
    chk("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
    chk("hold_slot_valid", {31'd0, if_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 10 && !if_valid; i++) step();
    chk("hold_discard_pc", if_pc, 32'h0000_0200);

    // Wrap-around from the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10 && !imem_req_valid; i++) step();
    chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    for (int i = 0; i < 10 && !(if_valid && if_pc == 32'hFFFF_FFFC); i++) step();
    chk("wrap_slot_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_next_addr", imem_addr, 32'h0000_0000);
    chk("wrap_next_req", {31'd0, imem_req_valid}, 32'd1);

    // Asynchronous reset in the middle of WAIT, then a stale response.
    lat_min = 3;
    lat_max = 3;
    step();
    chk("pre_reset_wait", {31'd0, imem_req_valid}, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    outstanding     = 1'b0;
    imem_resp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    exp_pc         = RESET_PC;
    imem_req_ready = 1'b0;
    stale          = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    step();
    step();
    stale           = 1'b0;
    imem_resp_valid = 1'b0;
    chk("stale_pc", pc, RESET_PC);
    chk("stale_if_valid", {31'd0, if_valid}, 32'd0);
    chk("stale_req", {31'd0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b1;
    lat_min = 1;
    lat_max = 1;
    step();
    step();
    chk("restart_valid", {31'd0, if_valid}, 32'd1);
    chk("restart_pc", if_pc, RESET_PC);
    chk("restart_instr", if_instr, RESET_PC ^ KEY);

    // Random traffic against the scoreboard and memory model.
    lat_min = 1;
    lat_max = 3;
    n_consumed = 0;
    for (int i = 0; i < 600; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom;
      step();
    end
    redirect_valid = 1'b0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    repeat (10) step();
    chk("random_progress", {31'd0, n_consumed >= 40}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
